// File: rtl/mem_port_arbiter.sv
// Fixed-priority / round-robin arbiter of NUM_CH memory requestors onto one RAMHelper port.
// Optional build macro MMIO_BYPASS_EN: sub-MEM_BASE requests bypass RAM and flag resp_mmio.
module mem_port_arbiter #(
    parameter int          NUM_CH   = 3,
    parameter int          ADDR_W   = 64,
    parameter int          DATA_W   = 64,
    parameter int          ARB_MODE = 0,
    parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_wen,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH*DATA_W-1:0] req_wmask,
    output logic [NUM_CH-1:0]        resp_valid,
    input  logic [NUM_CH-1:0]        resp_ready,
    output logic [DATA_W-1:0]        resp_rdata,
`ifdef MMIO_BYPASS_EN
    output logic                     resp_mmio,
`endif
    output logic                     ram_ren,
    output logic [63:0]              ram_ridx,
    input  logic [63:0]              ram_rdata,
    output logic                     ram_wen,
    output logic [63:0]              ram_widx,
    output logic [63:0]              ram_wdata,
    output logic [63:0]              ram_wmask
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MEM_BASE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                mmio_q, mmio_d;

    logic                gnt_found_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic [IDX_W-1:0]    cand_s;
    logic [NUM_CH-1:0]   gnt_oh_s;
    logic                accept_s;
    logic                grant_s;
    logic                mmio_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic                sel_wen_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [DATA_W-1:0]   sel_wmask_s;
    logic [63:0]         ram_idx_s;

    // Grant selection: lowest index, or rotating search starting after the last winner.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = {IDX_W{1'b0}};
        cand_s      = {IDX_W{1'b0}};
        if (ARB_MODE == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                gnt_found_s = gnt_found_s | req_valid[i];
                gnt_idx_s   = req_valid[i] ? IDX_W'(i) : gnt_idx_s;
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                cand_s      = IDX_W'((int'(rr_ptr_q) + k) % NUM_CH);
                gnt_idx_s   = (!gnt_found_s && req_valid[cand_s]) ? cand_s : gnt_idx_s;
                gnt_found_s = gnt_found_s | req_valid[cand_s];
            end
        end
    end

    assign accept_s    = |(resp_valid_q & resp_ready);
    assign grant_s     = reset && gnt_found_s && ((state_q == ST_IDLE) || accept_s);
    assign gnt_oh_s    = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_idx_s;
    assign sel_addr_s  = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
    assign sel_wen_s   = req_wen[gnt_idx_s];
    assign sel_wdata_s = req_wdata[gnt_idx_s*DATA_W +: DATA_W];
    assign sel_wmask_s = req_wmask[gnt_idx_s*DATA_W +: DATA_W];
    // Word index wraps modulo 2^ADDR_W for addresses below the RAM base.
    assign ram_idx_s   = 64'((sel_addr_s - BASE_A) >> 3'd3);

`ifdef MMIO_BYPASS_EN
    assign mmio_s = (sel_addr_s < BASE_A);
`else
    assign mmio_s = 1'b0;
`endif

    assign req_ready = grant_s ? gnt_oh_s : {NUM_CH{1'b0}};

    // RAM port driven straight from the grant; everything idles at zero otherwise.
    always_comb begin
        ram_ren   = 1'b0;
        ram_ridx  = 64'd0;
        ram_wen   = 1'b0;
        ram_widx  = 64'd0;
        ram_wdata = 64'd0;
        ram_wmask = 64'd0;
        if (grant_s && !mmio_s) begin
            if (sel_wen_s) begin
                ram_wen   = 1'b1;
                ram_widx  = ram_idx_s;
                ram_wdata = 64'(sel_wdata_s);
                ram_wmask = 64'(sel_wmask_s);
            end else begin
                ram_ren   = 1'b1;
                ram_ridx  = ram_idx_s;
            end
        end else begin
            ram_ren = 1'b0;
        end
    end

    // Next-state: a grant loads a fresh response, an accept without grant drains to idle.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        rr_ptr_d     = rr_ptr_q;
        mmio_d       = mmio_q;
        if (grant_s) begin
            state_d      = ST_RESP;
            resp_valid_d = gnt_oh_s;
            resp_rdata_d = (sel_wen_s || mmio_s) ? {DATA_W{1'b0}} : DATA_W'(ram_rdata);
            rr_ptr_d     = gnt_idx_s;
            mmio_d       = mmio_s;
        end else if (accept_s) begin
            state_d      = ST_IDLE;
            resp_valid_d = {NUM_CH{1'b0}};
            mmio_d       = 1'b0;
        end else begin
            state_d      = state_q;
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= {NUM_CH{1'b0}};
            resp_rdata_q <= {DATA_W{1'b0}};
            rr_ptr_q     <= IDX_W'(NUM_CH - 1);
            mmio_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            rr_ptr_q     <= rr_ptr_d;
            mmio_q       <= mmio_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
`ifdef MMIO_BYPASS_EN
    assign resp_mmio  = mmio_q;
`else
    logic unused_mmio_s;
    assign unused_mmio_s = mmio_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one fixed-priority and one round-robin instance
// share the request inputs; a table drives the fixed-priority instance cycle by cycle.
module tb_mem_port_arbiter;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   req_valid, req_wen, resp_ready;
    logic [191:0] req_addr, req_wdata, req_wmask;

    logic [2:0]   rdy0, rv0, rdy1, rv1;
    logic [63:0]  rd0, rd1, ridx0, ridx1, rdat0, rdat1, widx0, widx1;
    logic [63:0]  wdat0, wdat1, wmsk0, wmsk1;
    logic         ren0, ren1, wen0, wen1;
`ifdef MMIO_BYPASS_EN
    logic         mmio0, mmio1;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    function automatic logic [63:0] ram_model(input logic [63:0] idx);
        return 64'hC0DE_0000_0000_0000 ^ idx;
    endfunction

    assign rdat0 = ram_model(ridx0);
    assign rdat1 = ram_model(ridx1);

    mem_port_arbiter #(.NUM_CH(3), .ADDR_W(64), .DATA_W(64), .ARB_MODE(0), .MEM_BASE(B)) u_fp (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy0), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(rv0),
        .resp_ready(resp_ready), .resp_rdata(rd0),
`ifdef MMIO_BYPASS_EN
        .resp_mmio(mmio0),
`endif
        .ram_ren(ren0), .ram_ridx(ridx0), .ram_rdata(rdat0), .ram_wen(wen0), .ram_widx(widx0),
        .ram_wdata(wdat0), .ram_wmask(wmsk0));

    mem_port_arbiter #(.NUM_CH(3), .ADDR_W(64), .DATA_W(64), .ARB_MODE(1), .MEM_BASE(B)) u_rr (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(rv1),
        .resp_ready(resp_ready), .resp_rdata(rd1),
`ifdef MMIO_BYPASS_EN
        .resp_mmio(mmio1),
`endif
        .ram_ren(ren1), .ram_ridx(ridx1), .ram_rdata(rdat1), .ram_wen(wen1), .ram_widx(widx1),
        .ram_wdata(wdat1), .ram_wmask(wmsk1));

    typedef struct packed {
        logic        rst;
        logic [2:0]  valid;
        logic [2:0]  wen;
        logic [2:0]  rready;
        logic [63:0] a0;
        logic [63:0] a1;
        logic [63:0] a2;
        logic [2:0]  e_rdy;
        logic        e_ren;
        logic [63:0] e_ridx;
        logic        e_wen;
        logic [63:0] e_widx;
        logic [2:0]  e_rv;
        logic [63:0] e_rd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] valid, input logic [2:0] wen,
                         input logic [2:0] rready, input logic [63:0] a0,
                         input logic [63:0] a1, input logic [63:0] a2);
        reset      = rst;
        req_valid  = valid;
        req_wen    = wen;
        resp_ready = rready;
        req_addr   = {a2, a1, a0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] wrap_idx;
        logic [2:0]  one3;
        one3      = 3'b001;
        wrap_idx  = 64'h1FFF_FFFF_F000_0001;
        req_wdata = {64'h0000_0000_0000_2222, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_1111};
        req_wmask = {192{1'b1}};
        drive(1'b0, 3'b000, 3'b000, 3'b000, B, B, B);
        repeat (2) @(posedge clock);
        #1;

        // rst valid wen rready a0 a1 a2 | rdy ren ridx wen widx rv rd
        tbl[0]  = '{1'b0, 3'b011, 3'b000, 3'b000, B, B + 64'd8, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b000, 64'd0};
        tbl[1]  = '{1'b1, 3'b011, 3'b000, 3'b000, B, B + 64'd8, B,
                    3'b001, 1'b1, 64'd0, 1'b0, 64'd0, 3'b000, 64'd0};
        tbl[2]  = '{1'b1, 3'b010, 3'b000, 3'b111, B, B + 64'd8, B,
                    3'b010, 1'b1, 64'd1, 1'b0, 64'd0, 3'b001, ram_model(64'd0)};
        tbl[3]  = '{1'b1, 3'b000, 3'b000, 3'b111, B, B + 64'd8, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b010, ram_model(64'd1)};
        tbl[4]  = '{1'b1, 3'b010, 3'b010, 3'b000, B, B + 64'd16, B,
                    3'b010, 1'b0, 64'd0, 1'b1, 64'd2, 3'b000, 64'd0};
        tbl[5]  = '{1'b1, 3'b000, 3'b000, 3'b000, B, B, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b010, 64'd0};
        tbl[6]  = '{1'b1, 3'b001, 3'b000, 3'b000, B + 64'd24, B, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b010, 64'd0};
        tbl[7]  = '{1'b1, 3'b001, 3'b000, 3'b010, B + 64'd24, B, B,
                    3'b001, 1'b1, 64'd3, 1'b0, 64'd0, 3'b010, 64'd0};
        tbl[8]  = '{1'b1, 3'b100, 3'b000, 3'b000, B, B, B + 64'h100,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b001, ram_model(64'd3)};
        tbl[9]  = '{1'b1, 3'b100, 3'b000, 3'b100, B, B, B + 64'h100,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b001, ram_model(64'd3)};
        tbl[10] = '{1'b1, 3'b100, 3'b000, 3'b001, B, B, B + 64'h100,
                    3'b100, 1'b1, 64'h20, 1'b0, 64'd0, 3'b001, ram_model(64'd3)};
        tbl[11] = '{1'b1, 3'b000, 3'b000, 3'b100, B, B, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b100, ram_model(64'h20)};
`ifdef MMIO_BYPASS_EN
        tbl[12] = '{1'b1, 3'b001, 3'b000, 3'b000, 64'd8, B, B,
                    3'b001, 1'b0, 64'd0, 1'b0, 64'd0, 3'b000, 64'd0};
        tbl[13] = '{1'b1, 3'b000, 3'b000, 3'b001, B, B, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b001, 64'd0};
`else
        tbl[12] = '{1'b1, 3'b001, 3'b000, 3'b000, 64'd8, B, B,
                    3'b001, 1'b1, wrap_idx, 1'b0, 64'd0, 3'b000, 64'd0};
        tbl[13] = '{1'b1, 3'b000, 3'b000, 3'b001, B, B, B,
                    3'b000, 1'b0, 64'd0, 1'b0, 64'd0, 3'b001, ram_model(wrap_idx)};
`endif

        for (int v = 0; v < 14; v++) begin
            drive(tbl[v].rst, tbl[v].valid, tbl[v].wen, tbl[v].rready,
                  tbl[v].a0, tbl[v].a1, tbl[v].a2);
            #1;
            chk($sformatf("v%0d_req_ready", v), 64'(rdy0), 64'(tbl[v].e_rdy));
            chk($sformatf("v%0d_ram_ren", v), 64'(ren0), 64'(tbl[v].e_ren));
            chk($sformatf("v%0d_ram_ridx", v), ridx0, tbl[v].e_ridx);
            chk($sformatf("v%0d_ram_wen", v), 64'(wen0), 64'(tbl[v].e_wen));
            chk($sformatf("v%0d_ram_widx", v), widx0, tbl[v].e_widx);
            chk($sformatf("v%0d_resp_valid", v), 64'(rv0), 64'(tbl[v].e_rv));
            if (tbl[v].e_rv != 3'b000 || !tbl[v].rst) begin
                chk($sformatf("v%0d_resp_rdata", v), rd0, tbl[v].e_rd);
            end
            @(posedge clock);
            #1;
        end

        // Reset while a response is pending.
        drive(1'b1, 3'b001, 3'b000, 3'b000, B + 64'h28, B, B);
        #1;
        chk("rst_pre_grant", 64'(rdy0), 64'(3'b001));
        chk("rst_pre_ridx", ridx0, 64'd5);
        @(posedge clock);
        #1;
        drive(1'b0, 3'b001, 3'b000, 3'b001, B + 64'h28, B, B);
        #1;
        chk("rst_low_ready", 64'(rdy0), 64'd0);
        chk("rst_low_ren", 64'(ren0), 64'd0);
        chk("rst_low_rv_held", 64'(rv0), 64'(3'b001));
        @(posedge clock);
        #1;

        // Release with all channels valid: round-robin order 0,1,2,0,1,2.
        drive(1'b1, 3'b111, 3'b000, 3'b111, B, B + 64'd8, B + 64'd16);
        #1;
        chk("rst_done_rv_fp", 64'(rv0), 64'd0);
        chk("rst_done_rd_fp", rd0, 64'd0);
        chk("rst_done_ready_fp", 64'(rdy0), 64'(3'b001));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr%0d_ready", k), 64'(rdy1), 64'(one3 << (k % 3)));
            if (k == 0) begin
                chk("rr0_rv", 64'(rv1), 64'd0);
            end else begin
                chk($sformatf("rr%0d_rv", k), 64'(rv1), 64'(one3 << ((k - 1) % 3)));
                chk($sformatf("rr%0d_rd", k), rd1, ram_model(64'((k - 1) % 3)));
            end
            @(posedge clock);
            #1;
        end

        // Write on ch1 granted in the same cycle the pending response is accepted.
        drive(1'b1, 3'b010, 3'b010, 3'b111, B, B + 64'd16, B);
        #1;
        chk("wr_ready", 64'(rdy0), 64'(3'b010));
        chk("wr_ram_wen", 64'(wen0), 64'd1);
        chk("wr_ram_ren", 64'(ren0), 64'd0);
        chk("wr_ram_widx", widx0, 64'd2);
        chk("wr_ram_wdata", wdat0, 64'h0000_0000_DEAD_BEEF);
        chk("wr_ram_wmask", wmsk0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clock);
        #1;
        drive(1'b1, 3'b000, 3'b000, 3'b000, B, B, B);
        #1;
        chk("wr_resp_valid", 64'(rv0), 64'(3'b010));
        chk("wr_resp_rdata", rd0, 64'd0);
        drive(1'b1, 3'b000, 3'b000, 3'b010, B, B, B);
        @(posedge clock);
        #1;
        drive(1'b1, 3'b000, 3'b000, 3'b000, B, B, B);
        #1;
        chk("drain_rv", 64'(rv0), 64'd0);

`ifdef MMIO_BYPASS_EN
        drive(1'b1, 3'b010, 3'b000, 3'b000, B, 64'h0000_0000_0200_0000, B);
        #1;
        chk("mmio_ready", 64'(rdy0), 64'(3'b010));
        chk("mmio_ram_ren", 64'(ren0), 64'd0);
        @(posedge clock);
        #1;
        drive(1'b1, 3'b000, 3'b000, 3'b000, B, B, B);
        #1;
        chk("mmio_rv", 64'(rv0), 64'(3'b010));
        chk("mmio_rd", rd0, 64'd0);
        chk("mmio_flag", 64'(mmio0), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
